// File: rtl/sr_cmd_encoder.sv
// Command encoder for a bank of clocked SR flip-flops: one-cycle s/r drive pulse,
// settle, read-back check and bounded retry. Define SR_ERRCNT_EN to add a saturating err_cnt.
//
// state  | meaning
// IDLE   | waiting for a target word, tgt_ready high
// DRIVE  | one-cycle s/r excitation toward tgt_q
// SETTLE | s=r=0 while the bank settles, counting down SETTLE_CYC
// CHECK  | compare q_fb with tgt_q, finish or retry
module sr_cmd_encoder #(
  parameter int W          = 4,
  parameter int SETTLE_CYC = 2,
  parameter int MAX_RETRY  = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tgt_valid,
  input  logic [W-1:0] tgt_data,
  output logic         tgt_ready,
  output logic [W-1:0] s,
  output logic [W-1:0] r,
  input  logic [W-1:0] q_fb,
  output logic         done,
  output logic         err,
`ifdef SR_ERRCNT_EN
  output logic [7:0]   err_cnt,
`endif
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

  state_t       state, state_nxt;
  logic [W-1:0] tgt_q;
  logic [3:0]   settle_cnt;
  logic [2:0]   retry_cnt;
  logic         match;
  logic         retry_left;
  logic [W-1:0] drive_tgt;
  logic [W-1:0] s_nxt, r_nxt;
  logic         done_nxt, err_nxt;

  assign match      = (q_fb == tgt_q);
  assign retry_left = (retry_cnt < RETRY_MAX);
  assign tgt_ready  = (state == IDLE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tgt_valid) state_nxt = DRIVE;
      DRIVE:   state_nxt = SETTLE;
      SETTLE:  if (settle_cnt <= 4'd1) state_nxt = CHECK;
      CHECK:   state_nxt = (!match && retry_left) ? DRIVE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // s/r are computed one edge early so the pulse coincides exactly with the DRIVE
  // state; on accept the word comes straight from tgt_data since tgt_q is not yet loaded.
  always_comb begin
    drive_tgt = (state == IDLE) ? tgt_data : tgt_q;
    s_nxt     = '0;
    r_nxt     = '0;
    done_nxt  = 1'b0;
    err_nxt   = err;
    if (state_nxt == DRIVE) begin
      s_nxt = drive_tgt & ~q_fb;
      r_nxt = ~drive_tgt & q_fb;
    end
    if (state == CHECK && state_nxt == IDLE) begin
      done_nxt = 1'b1;
      err_nxt  = !match;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s    <= '0;
      r    <= '0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      s    <= s_nxt;
      r    <= r_nxt;
      done <= done_nxt;
      err  <= err_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tgt_q      <= '0;
      retry_cnt  <= '0;
      settle_cnt <= '0;
    end else begin
      if (state == IDLE && tgt_valid) begin
        tgt_q     <= tgt_data;
        retry_cnt <= '0;
      end else if (state == CHECK && state_nxt == DRIVE) begin
        retry_cnt <= retry_cnt + 3'd1;
      end
      if (state == DRIVE)
        settle_cnt <= SETTLE_LD;
      else if (state == SETTLE && settle_cnt != 4'd0)
        settle_cnt <= settle_cnt - 4'd1;
    end
  end

`ifdef SR_ERRCNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err_cnt <= 8'd0;
    else if (done_nxt && err_nxt && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_sr_cmd_encoder.sv
// Directed bench for sr_cmd_encoder with an ideal SR bank model and a stuck-at-0 mask.
module tb_sr_cmd_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       tgt_valid;
  logic [3:0] tgt_data;
  logic       tgt_ready;
  logic [3:0] s, r, q_fb;
  logic       done, err, busy;
`ifdef SR_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  logic [3:0] q_bank = 4'b0000;
  logic [3:0] stuck  = 4'b0000;
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) q_bank <= (q_bank & ~r) | s;
  assign q_fb = q_bank & ~stuck;

  sr_cmd_encoder #(.W(4), .SETTLE_CYC(2), .MAX_RETRY(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .tgt_valid (tgt_valid),
    .tgt_data  (tgt_data),
    .tgt_ready (tgt_ready),
    .s         (s),
    .r         (r),
    .q_fb      (q_fb),
    .done      (done),
    .err       (err),
`ifdef SR_ERRCNT_EN
    .err_cnt   (err_cnt),
`endif
    .busy      (busy)
  );

  task automatic send_cmd(input string name, input logic [3:0] d, input logic [3:0] exp_s,
                          input logic [3:0] exp_r, input int exp_pulses, input int exp_lat,
                          input logic exp_err, input logic [3:0] exp_q);
    int k = 0;
    int pulses = 0;
    int lat = -1;
    bit got = 0;
    bit s_bad = 0;
    bit inv_bad = 0;
    logic [3:0] s_first = '0, r_first = '0;
    logic e = 1'b0;
    tgt_data  = d;
    tgt_valid = 1'b1;
    @(posedge clk); #1;
    tgt_valid = 1'b0;
    n_assert++;
    if (busy !== 1'b1 || tgt_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s accept: busy=%b ready=%b, want busy=1 ready=0", name, busy, tgt_ready);
    end
    while (!got && k <= 40) begin
      if ((s & r) !== 4'b0000) inv_bad = 1;
      if (s !== 4'b0000 || r !== 4'b0000) begin
        if (pulses == 0) begin s_first = s; r_first = r; end
        else if (s !== exp_s) s_bad = 1;
        pulses++;
      end
      if (done === 1'b1) begin
        got = 1; lat = k; e = err;
      end else begin
        @(posedge clk); #1; k++;
      end
    end
    n_assert++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s timeout: no done within 40 cycles", name);
    end
    n_assert++;
    if (inv_bad) begin n_fail++; $display("FAIL %s s&r: overlap seen, want none", name); end
    n_assert++;
    if (pulses != exp_pulses) begin
      n_fail++;
      $display("FAIL %s pulses: got %0d, want %0d", name, pulses, exp_pulses);
    end
    if (exp_pulses > 0) begin
      n_assert++;
      if (s_first !== exp_s || r_first !== exp_r || s_bad) begin
        n_fail++;
        $display("FAIL %s drive: s=%b r=%b s_bad=%b, want s=%b r=%b", name, s_first, r_first,
                 s_bad, exp_s, exp_r);
      end
    end
    n_assert++;
    if (lat != exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d, want %0d", name, lat, exp_lat); end
    n_assert++;
    if (e !== exp_err) begin n_fail++; $display("FAIL %s err: got %b, want %b", name, e, exp_err); end
    n_assert++;
    if (q_fb !== exp_q) begin n_fail++; $display("FAIL %s q_fb: got %b, want %b", name, q_fb, exp_q); end
    @(posedge clk); #1;
    n_assert++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after done: done=%b busy=%b, want 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; tgt_valid = 1'b0; tgt_data = 4'b0000;
    #100;
    n_assert++;
    if (s !== 4'b0000 || r !== 4'b0000 || done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || tgt_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: s=%b r=%b done=%b err=%b busy=%b ready=%b", s, r, done, err, busy, tgt_ready);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_assert++;
    if (s !== 4'b0000 || r !== 4'b0000 || tgt_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset exit: s=%b r=%b ready=%b, want 0000 0000 1", s, r, tgt_ready);
    end
  endtask

  task automatic test_basic;
    send_cmd("first_set", 4'b1010, 4'b1010, 4'b0000, 1, 4, 1'b0, 4'b1010);
    send_cmd("mixed",     4'b0110, 4'b0100, 4'b1000, 1, 4, 1'b0, 4'b0110);
    send_cmd("noop",      4'b0110, 4'b0000, 4'b0000, 0, 4, 1'b0, 4'b0110);
  endtask

  task automatic test_stuck;
    stuck = 4'b0001;
    send_cmd("stuck", 4'b0001, 4'b0001, 4'b0110, 4, 16, 1'b1, 4'b0000);
    repeat (3) @(posedge clk);
    #1;
    n_assert++;
    if (err !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL err hold: err=%b done=%b, want 1 0", err, done);
    end
`ifdef SR_ERRCNT_EN
    n_assert++;
    if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL err_cnt one: got %0d, want 1", err_cnt); end
`endif
    stuck = 4'b0000;
  endtask

  task automatic test_reset_mid;
    tgt_data = 4'b1111; tgt_valid = 1'b1;
    @(posedge clk); #1;
    tgt_valid = 1'b0;
    @(posedge clk); #1;
    #2 reset = 1'b0;
    #1;
    n_assert++;
    if (s !== 4'b0000 || r !== 4'b0000 || busy !== 1'b0 || tgt_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset mid: s=%b r=%b busy=%b ready=%b done=%b", s, r, busy, tgt_ready, done);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_assert++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset mid done: got %b, want 0", done); end
      if (i == 2) reset = 1'b1;
    end
    n_assert++;
    if (tgt_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset release: ready=%b busy=%b err=%b, want 1 0 0", tgt_ready, busy, err);
    end
    send_cmd("post_reset", 4'b0101, 4'b0000, 4'b1010, 1, 4, 1'b0, 4'b0101);
  endtask

  task automatic test_back_to_back;
    logic [3:0] junk [4];
    junk[0] = 4'b1111; junk[1] = 4'b1000; junk[2] = 4'b0001; junk[3] = 4'b0110;
    tgt_data = 4'b0011; tgt_valid = 1'b1;
    for (int cmd = 0; cmd < 2; cmd++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        n_assert++;
        if (tgt_ready !== 1'b0 || busy !== 1'b1 || (s & r) !== 4'b0000) begin
          n_fail++;
          $display("FAIL backpressure %0d.%0d: ready=%b busy=%b s=%b r=%b", cmd, i, tgt_ready, busy, s, r);
        end
        tgt_data = junk[i];
        @(posedge clk); #1;
      end
      n_assert++;
      if (done !== 1'b1 || err !== 1'b0 || tgt_ready !== 1'b1 || q_fb !== (cmd == 0 ? 4'b0011 : 4'b1100)) begin
        n_fail++;
        $display("FAIL b2b done %0d: done=%b err=%b ready=%b q_fb=%b", cmd, done, err, tgt_ready, q_fb);
      end
      tgt_data = 4'b1100;
    end
    tgt_valid = 1'b0;
    @(posedge clk); #1;
  endtask

`ifdef SR_ERRCNT_EN
  task automatic test_errcnt_sat;
    stuck = 4'b0001;
    for (int n = 0; n < 256; n++) begin
      int k = 0;
      tgt_data = 4'b0001; tgt_valid = 1'b1;
      @(posedge clk); #1;
      tgt_valid = 1'b0;
      while (done !== 1'b1 && k < 40) begin @(posedge clk); #1; k++; end
      if (k >= 40) begin
        n_assert++; n_fail++;
        $display("FAIL errcnt timeout at command %0d", n);
        break;
      end
    end
    n_assert++;
    if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL err_cnt sat: got %0d, want 255", err_cnt); end
    stuck = 4'b0000;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stuck();
    test_reset_mid();
    test_back_to_back();
`ifdef SR_ERRCNT_EN
    test_errcnt_sat();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_cmd_encoder.md
Name: sr_cmd_encoder

Overview:
- Command-side encoder for a bank of clocked SR flip-flops: takes target register words over a valid/ready handshake and produces per-bit s/r excitation pulses.
- Reads back the flip-flop bank q outputs, checks that the bank reached the target, and retries on mismatch.
- Guarantees the forbidden s=1,r=1 combination is never driven.
- Sits between control logic and any sr-style storage bank in the design.

Parameters:
- W, 4, number of SR flip-flops driven (bit width of target, s, r, q_fb); legal range 1..32.
- SETTLE_CYC, 2, idle cycles after a drive pulse before q_fb is sampled; legal range 1..15.
- MAX_RETRY, 3, extra drive attempts after the first on mismatch; legal range 0..7.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- tgt_valid  input  1  target word offered.
- tgt_data  input  W  desired q value per bit.
- tgt_ready  output  1  encoder can accept a target (high only in IDLE).
- s  output  W  set excitation to the SR bank, registered.
- r  output  W  reset excitation to the SR bank, registered.
- q_fb  input  W  current q of the SR bank, same clock domain.
- done  output  1  one-cycle pulse when a command completes.
- err  output  1  valid with done: 1 means the target was not reached after all retries.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, s=0, r=0, done=0, err=0, busy=0, tgt_ready=1.
  - Target register, settle counter and retry counter cleared.
- IDLE:
  - tgt_ready=1.
  - On clk edge with tgt_valid=1, latch tgt_data into tgt_q, clear retry counter, go to DRIVE.
  - Accept is therefore same-edge. tgt_valid while busy is ignored (tgt_ready=0); no queueing.
- DRIVE (exactly 1 cycle):
  - Registered outputs per bit i:
    - tgt_q[i]=1 and q_fb[i]=0 -> s[i]=1, r[i]=0.
    - tgt_q[i]=0 and q_fb[i]=1 -> s[i]=0, r[i]=1.
    - otherwise s[i]=r[i]=0 (hold).
  - s and r are high for exactly one clk period, then return to 0.
  - Go to SETTLE with the settle counter loaded to SETTLE_CYC.
- SETTLE:
  - s=r=0.
  - Decrement each cycle; on reaching 0 go to CHECK.
- CHECK (1 cycle): compare q_fb to tgt_q.
  - Match -> done=1, err=0, go to IDLE.
  - Mismatch and retry<MAX_RETRY -> retry+1, go to DRIVE.
  - Mismatch and retry==MAX_RETRY -> done=1, err=1, go to IDLE.
- err holds its value until the next done pulse. done is a single-cycle pulse.
- Invariant: (s & r)==0 every cycle, including reset exit.
- Latency, first-try success, accept edge to done pulse: 1 (DRIVE) + SETTLE_CYC + 1 (CHECK) cycles. Default = 4.
- Target equal to current q_fb: DRIVE issues all-zero s/r, CHECK passes, done with err=0.
- Reset mid-operation: s/r drop to 0 immediately (asynchronous), command discarded, no done pulse.
- q_fb changing during SETTLE is ignored; only the CHECK-cycle value counts.

Optional Feature:
- SR_ERRCNT_EN defined:
  - Adds output err_cnt, 8 bits, reset 0.
  - Increments on each done with err=1.
  - Saturates at 255 and never wraps.
  - Cleared only by reset.
- SR_ERRCNT_EN undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then first command: hold reset=0 for 100 ns, release, offer tgt_data=4'b1010 with q_fb=0000 and an ideal SR model -> one cycle s=1010 r=0000, done 4 cycles after accept, err=0, q_fb=1010.
- Mixed set/reset: from q_fb=1010 send 4'b0110 -> single DRIVE cycle s=0100, r=1000, done with err=0.
- No-op target: from q_fb=0110 send 0110 -> s=r=0 throughout, done with err=0.
- Stuck bit: model forces q_fb[0]=0, send 0001 -> exactly 4 DRIVE pulses (1+MAX_RETRY) with s=0001, then done with err=1, total 16 cycles. With SR_ERRCNT_EN: err_cnt=1; repeat 256 times -> err_cnt stays 255.
- Reset mid-operation: assert reset during SETTLE -> s=r=0 asynchronously, no done pulse, tgt_ready=1 after release, next command completes normally.
- Back-pressure and invariant: hold tgt_valid=1 continuously with changing data -> tgt_ready=0 while busy, only IDLE-cycle values accepted; assertion (s&r)==0 holds over the whole run.
